// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch buffer.
//   INSTR_W    - instruction word width
//   MAX_PC_W   - storage width of the pc field; the real PC width (WIDTH
//                parameter of the users) is zero-extended into it and
//                synthesis trims the unused upper bits
//   NOP_INSTR  - word presented for entries that never go to memory
//   fetch_entry_t - one reservation-queue entry
package fetch_pkg;
  localparam int INSTR_W  = 32;
  localparam int MAX_PC_W = 64;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [MAX_PC_W-1:0] pc;
    logic [INSTR_W-1:0]  data;
    logic                filled;
    logic                misaligned;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_slot_array.sv
// fetch_slot_array: DEPTH-entry in-order storage for fetched instructions.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   clr           - drop every entry at this edge (flush)
//   alloc         - allocate tail entry with alloc_pc / alloc_mis
//   fill          - write fill_data into the oldest unfilled entry
//   pop           - retire the head entry
//   head_ent      - current head entry
//   unfilled_cnt  - allocated entries still waiting for memory data
import fetch_pkg::*;

module fetch_slot_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       alloc,
  input  logic [WIDTH-1:0]           alloc_pc,
  input  logic                       alloc_mis,
  input  logic                       fill,
  input  logic [INSTR_W-1:0]         fill_data,
  input  logic                       pop,
  output fetch_entry_t               head_ent,
  output logic [$clog2(DEPTH+1)-1:0] unfilled_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     ent [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [PTR_W-1:0] head, tail, fill_ptr, idx;
  logic             fill_found;

  // Misaligned entries are born filled, so the fill target is found by
  // scanning from head for the first busy entry without data rather than
  // by a free-running pointer.
  always_comb begin
    fill_ptr     = '0;
    fill_found   = 1'b0;
    unfilled_cnt = '0;
    idx          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (busy[idx] && !ent[idx].filled) begin
        unfilled_cnt = unfilled_cnt + CNT_W'(1);
        if (!fill_found) begin
          fill_ptr   = idx;
          fill_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      head <= '0;
      tail <= '0;
      busy <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i].filled <= 1'b0;
    end else begin
      if (alloc) begin
        ent[tail].pc         <= MAX_PC_W'(alloc_pc);
        ent[tail].misaligned <= alloc_mis;
        ent[tail].filled     <= alloc_mis;
        ent[tail].data       <= NOP_INSTR;
        busy[tail]           <= 1'b1;
        tail                 <= tail + PTR_W'(1);
      end
      // A slot allocated this edge is not busy yet, and head is filled
      // whenever it pops, so fill never collides with alloc or pop.
      if (fill && fill_found) begin
        ent[fill_ptr].filled <= 1'b1;
        ent[fill_ptr].data   <= fill_data;
      end
      if (pop) begin
        busy[head]       <= 1'b0;
        ent[head].filled <= 1'b0;
        head             <= head + PTR_W'(1);
      end
    end
  end

  assign head_ent = ent[head];
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: fetch stage between the PC register and decode. Issues one
// read per cycle to a fixed-latency in-order instruction memory, queues the
// returned words with their PCs, and hands them to decode by valid/ready.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   pc_i / pc_stall          - current PC / hold request back to the PC reg
//   flush                    - branch taken; discard all wrong-path work
//   imem_req/imem_addr       - memory read request
//   imem_rvalid/imem_rdata   - memory return, MEM_LAT cycles after request
//   instr_valid/instr_ready  - decode handshake on the head entry
//   instr_o/instr_pc_o       - head instruction and its PC
//   instr_misaligned_o       - head PC not word aligned
// Optional feature macro: FETCH_BUF_ALIGN_CHECK_EN - misaligned PCs are
// queued as NOPs without a memory read; when undefined, instr_misaligned_o
// is 0 and the low PC bits are not inspected.
import fetch_pkg::*;

module fetch_buffer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   pc_i,
  output logic               pc_stall,
  input  logic               flush,
  output logic               imem_req,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_o,
  output logic [WIDTH-1:0]   instr_pc_o,
  output logic               instr_misaligned_o
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int DSC_W = $clog2(DEPTH+MEM_LAT+1);

  logic [CNT_W-1:0] alloc_cnt, unfilled_cnt;
  logic [DSC_W-1:0] discard_cnt;
  logic             slot_free, mis, pop, rv_old, rv_live, fill;
  fetch_entry_t     head_ent;
  logic             unused_fields;

`ifdef FETCH_BUF_ALIGN_CHECK_EN
  assign mis                = (pc_i[1:0] != 2'b00);
  assign instr_misaligned_o = head_ent.misaligned;
`else
  assign mis                = 1'b0;
  assign instr_misaligned_o = 1'b0;
`endif

  // Issue looks at the registered count only: a full queue stalls even when
  // decode pops in the same cycle.
  assign slot_free   = !rst && !flush && (alloc_cnt < CNT_W'(DEPTH));
  assign imem_req    = slot_free && !mis;
  assign imem_addr   = pc_i;
  assign pc_stall    = !rst && !flush && (alloc_cnt == CNT_W'(DEPTH));

  assign instr_valid = !rst && head_ent.filled;
  assign instr_o     = head_ent.data;
  assign instr_pc_o  = head_ent.pc[WIDTH-1:0];
  assign pop         = instr_valid && instr_ready && !flush;

  // Returns owed to flushed entries are swallowed before any live fill.
  assign rv_old      = imem_rvalid && (discard_cnt != '0);
  assign rv_live     = imem_rvalid && (discard_cnt == '0);
  assign fill        = rv_live && !flush;

  // Upper pc storage bits and the misaligned flag are not read in every build.
  assign unused_fields = ^{head_ent.pc, head_ent.misaligned};

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_cnt   <= '0;
      discard_cnt <= '0;
    end else if (flush) begin
      alloc_cnt   <= '0;
      // Every unfilled entry still has a return on the way, except one whose
      // data lands right now (and is dropped with the flush).
      discard_cnt <= discard_cnt - DSC_W'(rv_old) + DSC_W'(unfilled_cnt) - DSC_W'(rv_live);
    end else begin
      alloc_cnt   <= alloc_cnt + CNT_W'(slot_free) - CNT_W'(pop);
      discard_cnt <= discard_cnt - DSC_W'(rv_old);
    end
  end

  fetch_slot_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_slots (
    .clk          (clk),
    .rst          (rst),
    .clr          (flush),
    .alloc        (slot_free),
    .alloc_pc     (pc_i),
    .alloc_mis    (mis),
    .fill         (fill),
    .fill_data    (imem_rdata),
    .pop          (pop),
    .head_ent     (head_ent),
    .unfilled_cnt (unfilled_cnt)
  );

`ifndef SYNTHESIS
  // A return with nothing owed and nothing waiting means the memory and this
  // block disagree about outstanding reads.
  a_no_stray_return: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (discard_cnt == '0) && (unfilled_cnt == '0)));
`endif
endmodule
